mips_dmem_master: RTL and testbench

// CPU-side initiator for the word-addressed data memory interface (DataMem_*). Takes one

---
 rtl/mips_dmem_master.sv | 155 +++++++++++++++
 tb/tb_mips_dmem_master.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_dmem_master.sv
// Purpose: CPU-side load/store initiator for the word-addressed DataMem_* bus.
// Latency: Each request is answered by one rsp_valid pulse. A load with a 1-cycle memory responds 3 cycles after accept. A posted store responds after 2 cycles. A misaligned request responds after 1 cycle. A timeout responds after TIMEOUT_CYCLES+1 cycles.
// Backpressure: One request at a time. req_ready is high only in IDLE. rsp_valid is a one-cycle pulse with no ready.
// Ports: clock/reset_n; req_* request channel (valid/ready); rsp_* completion pulse with
//   extended load data and error code; DataMem_* word-addressed memory bus, big-endian lanes.
module mips_dmem_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          WRITE_ACK      = 1'b0
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err,
  output logic        DataMem_Read,
  output logic [3:0]  DataMem_Write,
  output logic [29:0] DataMem_Address,
  output logic [31:0] DataMem_Out,
  input  logic [31:0] DataMem_In,
  input  logic        DataMem_Ready
);

  // Counter value on the last waiting cycle before giving up.
  localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2, RSP = 2'd3} state_t;

  state_t      state, nextState;
  logic [15:0] waitCnt;
  logic [1:0]  offsetQ, sizeQ, errQ;
  logic        signedQ;
  logic [29:0] wordAddrQ;
  logic [31:0] wdataQ, rdataQ;
  logic [3:0]  strobeQ;

  logic        accept, waiting, timedOut, reqMisaligned;
  logic [3:0]  reqStrobe;
  logic [31:0] reqData, loadValue;
  logic [7:0]  loadByte;
  logic [15:0] loadHalf;

  assign accept  = req_valid && (state == IDLE);
  // Only states that wait on DataMem_Ready run the timeout counter.
  assign waiting = (state == RD) || ((state == WR) && WRITE_ACK);
  assign timedOut = waiting && !DataMem_Ready && (waitCnt == TimeoutLast);

  // Lane strobes and replicated write data for the incoming request.
  always_comb begin
    reqStrobe     = 4'b1111;
    reqData       = req_wdata;
    reqMisaligned = 1'b0;
    case (req_size)
      2'd0: begin
        reqStrobe = 4'b1000 >> req_addr[1:0];
        reqData   = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        reqStrobe     = req_addr[1] ? 4'b0011 : 4'b1100;
        reqData       = {2{req_wdata[15:0]}};
        reqMisaligned = req_addr[0];
      end
      default: reqMisaligned = (req_addr[1:0] != 2'b00);
    endcase
  end

  // Big-endian lane extraction: offset 0 is the most significant byte.
  always_comb begin
    case (offsetQ)
      2'd0:    loadByte = DataMem_In[31:24];
      2'd1:    loadByte = DataMem_In[23:16];
      2'd2:    loadByte = DataMem_In[15:8];
      default: loadByte = DataMem_In[7:0];
    endcase
    loadHalf = offsetQ[1] ? DataMem_In[15:0] : DataMem_In[31:16];
    case (sizeQ)
      2'd0:    loadValue = signedQ ? {{24{loadByte[7]}}, loadByte} : {24'd0, loadByte};
      2'd1:    loadValue = signedQ ? {{16{loadHalf[15]}}, loadHalf} : {16'd0, loadHalf};
      default: loadValue = DataMem_In;
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nextState;
  end

  // Next-state logic
  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (accept) nextState = reqMisaligned ? RSP : (req_write ? WR : RD);
      RD:   if (DataMem_Ready || timedOut) nextState = RSP;
      WR:   if (!WRITE_ACK || DataMem_Ready || timedOut) nextState = RSP;
      default: nextState = IDLE;
    endcase
  end

  // Request capture, load data capture and wait counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      waitCnt   <= '0;
      offsetQ   <= '0;
      sizeQ     <= '0;
      signedQ   <= 1'b0;
      errQ      <= '0;
      wordAddrQ <= '0;
      wdataQ    <= '0;
      strobeQ   <= '0;
      rdataQ    <= '0;
    end else if (accept) begin
      waitCnt <= '0;
      offsetQ <= req_addr[1:0];
      sizeQ   <= req_size;
      signedQ <= req_signed;
      rdataQ  <= '0;
      errQ    <= reqMisaligned ? 2'b01 : 2'b00;
      // A misaligned request never touches the bus, so leave the bus registers alone.
      if (!reqMisaligned) begin
        wordAddrQ <= req_addr[31:2];
        wdataQ    <= reqData;
        strobeQ   <= reqStrobe;
      end
    end else if (waiting) begin
      if (DataMem_Ready) begin
        if (state == RD) rdataQ <= loadValue;
      end else if (timedOut) begin
        errQ <= 2'b10;
      end else begin
        waitCnt <= waitCnt + 16'd1;
      end
    end
  end

  // Outputs. Read drops combinationally on Ready so the memory sees exactly one read.
  always_comb begin
    req_ready     = (state == IDLE);
    rsp_valid     = (state == RSP);
    rsp_rdata     = (state == RSP) ? rdataQ : 32'd0;
    rsp_err       = (state == RSP) ? errQ : 2'b00;
    DataMem_Read  = (state == RD) && !DataMem_Ready;
    DataMem_Write = (state == WR) ? strobeQ : 4'b0000;
  end

  assign DataMem_Address = wordAddrQ;
  assign DataMem_Out     = wdataQ;

endmodule

// File: tb/tb_mips_dmem_master.sv
module tb_mips_dmem_master;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, DataMem_Read;
  logic [31:0] rsp_rdata, DataMem_Out;
  logic [1:0]  rsp_err;
  logic [3:0]  DataMem_Write;
  logic [29:0] DataMem_Address;
  logic [31:0] memIn = '0;
  logic        memReady = 1'b0;

  mips_dmem_master #(.TIMEOUT_CYCLES(8), .WRITE_ACK(1'b0)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .DataMem_Read(DataMem_Read), .DataMem_Write(DataMem_Write),
    .DataMem_Address(DataMem_Address), .DataMem_Out(DataMem_Out),
    .DataMem_In(memIn), .DataMem_Ready(memReady)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cycle = 0;
  always @(posedge clock) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: 16 mapped words, 1-cycle read latency, byte-lane writes.
  logic [31:0] mem [16];
  always @(posedge clock) begin
    memReady <= 1'b0;
    memIn    <= '0;
    if (DataMem_Read && DataMem_Address < 30'd16) begin
      memReady <= 1'b1;
      memIn    <= mem[DataMem_Address[3:0]];
    end
    if (DataMem_Address < 30'd16)
      for (int i = 0; i < 4; i++)
        if (DataMem_Write[i]) mem[DataMem_Address[3:0]][8*i +: 8] <= DataMem_Out[8*i +: 8];
  end

  // Bus activity recorder
  int readCycles = 0, writeCycles = 0, conflicts = 0;
  logic [3:0]  lastWrite = '0;
  logic [31:0] lastOut = '0;
  logic [29:0] lastAddr = '0;
  always @(negedge clock) begin
    if (DataMem_Read) begin
      readCycles++;
      lastAddr = DataMem_Address;
    end
    if (|DataMem_Write) begin
      writeCycles++;
      lastWrite = DataMem_Write;
      lastOut   = DataMem_Out;
      lastAddr  = DataMem_Address;
    end
    if (DataMem_Read && |DataMem_Write) conflicts++;
  end

  // Scoreboard
  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } exp_t;
  exp_t expQ[$];

  always @(negedge clock) begin
    if (reset_n && rsp_valid) begin
      if (expQ.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("rsp_rdata", rsp_rdata, e.data);
        chk("rsp_err", 32'(rsp_err), 32'(e.err));
        chk("rsp_latency", 32'(cycle - e.acc + 1), 32'(e.lat));
      end
    end
  end

  // Present a request, wait for accept, then wait for its response.
  task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd, output int acc);
    int n;
    @(negedge clock);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg;
    req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (!req_ready) chk("accept_timeout", 32'd0, 32'd1);
    acc = cycle + 1;
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic doReq(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] expData, input logic [1:0] expErr, input int expLat,
                       output int rdDelta, output int wrDelta);
    int rd0, wr0, acc, n;
    exp_t e;
    rd0 = readCycles;
    wr0 = writeCycles;
    issue(w, sz, sg, addr, wd, acc);
    e.data = expData; e.err = expErr; e.lat = expLat; e.acc = acc;
    expQ.push_back(e);
    n = 0;
    while (expQ.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (expQ.size() != 0) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      expQ.delete();
    end
    @(negedge clock);
    rdDelta = readCycles - rd0;
    wrDelta = writeCycles - wr0;
  endtask

  initial begin
    int rd, wr, acc;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[4] = 32'hDEADBEEF;
    mem[8] = 32'hDEADBEEF;

    // Reset state
    #12;
    chk("reset_req_ready", 32'(req_ready), 32'd1);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset_read", 32'(DataMem_Read), 32'd0);
    chk("reset_write", 32'(DataMem_Write), 32'd0);
    chk("reset_addr", 32'(DataMem_Address), 32'd0);
    chk("reset_out", DataMem_Out, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // lw 0x10
    doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 3, rd, wr);
    chk("lw_read_cycles", 32'(rd), 32'd1);
    chk("lw_address", 32'(lastAddr), 32'd4);
    // lb signed 0x13, lbu 0x11
    doReq(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 32'hFFFFFFEF, 2'b00, 3, rd, wr);
    doReq(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'h000000AD, 2'b00, 3, rd, wr);
    // sh 0x22 data 0x1234, then re-read
    doReq(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234, 32'h0, 2'b00, 2, rd, wr);
    chk("sh_write_cycles", 32'(wr), 32'd1);
    chk("sh_strobe", 32'(lastWrite), 32'h3);
    chk("sh_out", lastOut, 32'h12341234);
    chk("sh_address", 32'(lastAddr), 32'd8);
    doReq(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'hDEAD1234, 2'b00, 3, rd, wr);
    // sb 0x23, lh signed 0x20, lhu 0x22, size 3 read
    doReq(1'b1, 2'd0, 1'b0, 32'h23, 32'h000000A5, 32'h0, 2'b00, 2, rd, wr);
    chk("sb_strobe", 32'(lastWrite), 32'h1);
    chk("sb_out", lastOut, 32'hA5A5A5A5);
    doReq(1'b0, 2'd1, 1'b1, 32'h20, 32'h0, 32'hFFFFDEAD, 2'b00, 3, rd, wr);
    doReq(1'b0, 2'd1, 1'b0, 32'h22, 32'h0, 32'h000012A5, 2'b00, 3, rd, wr);
    doReq(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 3, rd, wr);
    // Misaligned sw 0x2 and lh 0x21
    doReq(1'b1, 2'd2, 1'b0, 32'h2, 32'hCAFEF00D, 32'h0, 2'b01, 1, rd, wr);
    chk("misaligned_sw_reads", 32'(rd), 32'd0);
    chk("misaligned_sw_writes", 32'(wr), 32'd0);
    doReq(1'b0, 2'd1, 1'b1, 32'h21, 32'h0, 32'h0, 2'b01, 1, rd, wr);
    chk("misaligned_lh_reads", 32'(rd), 32'd0);
    // Unmapped load times out after 8 read cycles
    doReq(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h0, 2'b10, 9, rd, wr);
    chk("timeout_read_cycles", 32'(rd), 32'd8);

    // Reset while waiting in RD
    issue(1'b0, 2'd2, 1'b0, 32'h200, 32'h0, acc);
    repeat (3) @(negedge clock);
    chk("rd_before_reset", 32'(DataMem_Read), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rd_dropped_on_reset", 32'(DataMem_Read), 32'd0);
    chk("ready_on_reset", 32'(req_ready), 32'd1);
    chk("addr_on_reset", 32'(DataMem_Address), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    doReq(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 2'b00, 3, rd, wr);
    chk("post_reset_read_cycles", 32'(rd), 32'd1);

    chk("read_write_conflicts", 32'(conflicts), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
